// File: rtl/muldiv_iter_ctrl_pkg.sv
// Shared core types for the iterative multiply/divide sequencer.
// Holds the operation encoding, the sequencer state encoding and the
// default sizing constants used by muldiv_iter_ctrl.
package muldiv_iter_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULL = 2'd0,
    MD_MULH = 2'd1,
    MD_DIV  = 2'd2,
    MD_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam int MD_WIDTH    = 32;
  localparam int MD_CNT_W    = 6;
  // First counter value in CALC: one step per operand bit, counting down to 0.
  localparam int MD_CNT_INIT = MD_WIDTH - 1;

endpackage

// File: rtl/muldiv_addsub.sv
// Shared (W)-bit adder/subtractor for the multiply/divide sequencer.
// sub_i=1 computes a - b as a + ~b + cin_i (caller drives cin_i=1).
// bo_o is the carry out when adding and the borrow out when subtracting.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         bo_o
);

  logic [W-1:0] b_eff;
  logic         co;

  // Single carry chain; subtraction is add of the inverted operand.
  always_comb begin
    b_eff       = sub_i ? ~b_i : b_i;
    {co, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, cin_i};
    bo_o        = sub_i ? ~co : co;
  end

endmodule

// File: rtl/muldiv_iter_ctrl.sv
// Iterative radix-2 multiply/divide sequencer (RV32M path).
// Operands are reduced to magnitudes on accept, WIDTH shift/add or
// restoring-divide steps run on one shared adder, and the sign is applied
// in FIX by a two's-complement negate through the same adder.
// Optional macro MULDIV_FAST_ZERO_EN: zero operands skip straight to DONE.
module muldiv_iter_ctrl
  import muldiv_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  md_op_e           op_i,
  input  logic             signed_a_i,
  input  logic             signed_b_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  // Package constant is expressed for the default width; shift it to WIDTH.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_CNT_INIT + WIDTH - MD_WIDTH);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             fix_hi_q, fix_hi_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;       // upper accumulator or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier / product low or dividend / quotient
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   as_a, as_b, as_sum;
  logic             as_sub, as_cin, as_bo;
  logic [WIDTH-1:0] fix_x;
  logic             neg_a, neg_b, mul_i, mul_q;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign neg_a = signed_a_i & op_a_i[WIDTH-1];
  assign neg_b = signed_b_i & op_b_i[WIDTH-1];
  assign mag_a = neg_a ? (~op_a_i + WIDTH'(1)) : op_a_i;
  assign mag_b = neg_b ? (~op_b_i + WIDTH'(1)) : op_b_i;
  assign mul_i = (op_i == MD_MULL) || (op_i == MD_MULH);
  assign mul_q = (op_q == MD_MULL) || (op_q == MD_MULH);

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .cin_i (as_cin),
    .sum_o (as_sum),
    .bo_o  (as_bo)
  );

  // Next-state, datapath steering and adder operand selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    fix_hi_d = fix_hi_q;
    carry_d  = carry_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    as_a     = '0;
    as_b     = '0;
    as_sub   = 1'b0;
    as_cin   = 1'b0;
    fix_x    = '0;
    case (state_q)
      MD_IDLE: begin
        if (req_valid_i && !flush_i) begin
          op_d     = op_i;
          opnd_d   = mul_i ? mag_a : mag_b;
          lo_d     = mul_i ? mag_b : mag_a;
          hi_d     = '0;
          cnt_d    = CNT_INIT;
          fix_hi_d = 1'b0;
          carry_d  = 1'b0;
          case (op_i)
            MD_DIV:  neg_d = (neg_a ^ neg_b) && (op_b_i != '0);
            MD_REM:  neg_d = neg_a;
            default: neg_d = neg_a ^ neg_b;
          endcase
`ifdef MULDIV_FAST_ZERO_EN
          if ((op_b_i == '0) || (mul_i && (op_a_i == '0))) begin
            state_d = MD_DONE;
            res_d   = mul_i ? '0 : ((op_i == MD_DIV) ? '1 : op_a_i);
          end else begin
            state_d = MD_CALC;
          end
`else
          state_d = MD_CALC;
`endif
        end
      end
      MD_CALC: begin
        if (mul_q) begin
          // Conditional add into the upper half, then shift the pair right.
          as_a = {1'b0, hi_q};
          as_b = lo_q[0] ? {1'b0, opnd_q} : '0;
          hi_d = as_sum[WIDTH:1];
          lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
        end else begin
          // Restoring step: trial-subtract the divisor from the shifted remainder.
          as_a   = {hi_q, lo_q[WIDTH-1]};
          as_b   = {1'b0, opnd_q};
          as_sub = 1'b1;
          as_cin = 1'b1;
          hi_d   = as_bo ? as_a[WIDTH-1:0] : as_sum[WIDTH-1:0];
          lo_d   = {lo_q[WIDTH-2:0], ~as_bo};
        end
        if (cnt_q == '0) state_d = MD_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      MD_FIX: begin
        // Conditional negate; MULH needs the low-half carry before the high half.
        case (op_q)
          MD_MULH: fix_x = fix_hi_q ? hi_q : lo_q;
          MD_REM:  fix_x = hi_q;
          default: fix_x = lo_q;
        endcase
        as_a   = {1'b0, neg_q ? ~fix_x : fix_x};
        as_cin = fix_hi_q ? carry_q : neg_q;
        if ((op_q == MD_MULH) && !fix_hi_q) begin
          carry_d  = as_sum[WIDTH];
          fix_hi_d = 1'b1;
        end else begin
          res_d   = as_sum[WIDTH-1:0];
          state_d = MD_DONE;
        end
      end
      MD_DONE: if (rsp_ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MULL;
      neg_q    <= 1'b0;
      fix_hi_q <= 1'b0;
      carry_q  <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      fix_hi_q <= fix_hi_d;
      carry_q  <= carry_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == MD_IDLE);
  assign busy_o      = (state_q != MD_IDLE);
  assign rsp_valid_o = (state_q == MD_DONE);
  assign result_o    = res_q;

endmodule

// File: tb/tb_muldiv_iter_ctrl.sv
// Self-checking bench for muldiv_iter_ctrl: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_iter_ctrl;
  import muldiv_iter_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  md_op_e       op_i;
  logic         signed_a_i, signed_b_i;
  logic [W-1:0] op_a_i, op_b_i;
  logic         flush_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [W-1:0] result_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  muldiv_iter_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .signed_a_i(signed_a_i), .signed_b_i(signed_b_i), .op_a_i(op_a_i),
    .op_b_i(op_b_i), .flush_i(flush_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from whole-number arithmetic.
  function automatic logic [31:0] ref_md(md_op_e op, logic sa, logic sb, logic [31:0] a, logic [31:0] b);
    longint va, vb, q;
    logic [63:0] p;
    va = sa ? longint'($signed(a)) : longint'(a);
    vb = sb ? longint'($signed(b)) : longint'(b);
    p  = 64'(va * vb);
    case (op)
      MD_MULL: return p[31:0];
      MD_MULH: return p[63:32];
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = va / vb;
        return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = va % vb;
        return q[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(md_op_e op, logic [31:0] a, logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if ((b == 0) || (((op == MD_MULL) || (op == MD_MULH)) && (a == 0))) return 1;
`endif
    return (op == MD_MULH) ? W + 3 : W + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input md_op_e op, input logic sa, input logic sb,
                      input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    op_i = op; signed_a_i = sa; signed_b_i = sb; op_a_i = a; op_b_i = b;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("accept_wait", 64'(n < 100), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // lat counts edges from accept to the edge that first samples rsp_valid_o high.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int c = 0; c < 200; c++) begin
      if (rsp_valid_o) begin
        lat = c + 1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic do_op(input string tag, input md_op_e op, input logic sa, input logic sb,
                       input logic [31:0] a, input logic [31:0] b, input int rdly);
    int lat;
    logic [31:0] exp;
    exp = ref_md(op, sa, sb, a, b);
    send(op, sa, sb, a, b);
    wait_rsp(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, a, b)));
    check({tag, "_res"}, 64'(result_o), 64'(exp));
    repeat (rdly) @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check({tag, "_idle"}, {62'd0, rsp_valid_o, req_ready_o}, 64'b01);
  endtask

  initial begin
    int lat1, lat2, gap, pulses;
    logic [31:0] res1, ref_res;
    logic stable, seen1;

    rst_ni = 1'b0; req_valid_i = 1'b0; op_i = MD_MULL; signed_a_i = 1'b0; signed_b_i = 1'b0;
    op_a_i = '0; op_b_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", {29'd0, req_ready_o, rsp_valid_o, busy_o, result_o}, {29'd0, 3'b100, 32'd0});
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Back-to-back MULL with rsp_ready_i tied high.
    rsp_ready_i = 1'b1;
    send(MD_MULL, 1'b0, 1'b0, 32'd7, 32'd6);
    req_valid_i = 1'b1; op_a_i = 32'd3; op_b_i = 32'd5;
    lat1 = 0; gap = 0; res1 = '0; seen1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rsp_valid_o && !seen1) begin seen1 = 1'b1; lat1 = c + 1; res1 = result_o; end
      if (req_ready_o) begin gap = c + 1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("b2b_first_res", 64'(res1), 64'd42);
    check("b2b_first_lat", 64'(lat1), 64'(W + 2));
    check("b2b_accept_gap", 64'(gap), 64'(W + 3));
    wait_rsp(lat2);
    check("b2b_second_lat", 64'(lat2), 64'(W + 2));
    check("b2b_second_res", 64'(result_o), 64'd15);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;

    // Directed arithmetic and boundary cases.
    do_op("mulh_ss", MD_MULH, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mulh_uu", MD_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("div_neg", MD_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem_neg", MD_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu", MD_DIV, 1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op("remu", MD_REM, 1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op("div_by0", MD_DIV, 1'b1, 1'b1, 32'd5, 32'd0, 0);
    do_op("rem_by0", MD_REM, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
    do_op("div_ovf", MD_DIV, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", MD_REM, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("mull_0", MD_MULL, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 0);
    do_op("mulh_su", MD_MULH, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h8000_0001, 2);

    // Response held in DONE for 10 cycles.
    ref_res = ref_md(MD_DIV, 1'b0, 1'b0, 32'd1000, 32'd9);
    send(MD_DIV, 1'b0, 1'b0, 32'd1000, 32'd9);
    wait_rsp(lat1);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      stable &= rsp_valid_o && (result_o == ref_res) && !req_ready_o && busy_o;
      @(negedge clk_i);
    end
    check("hold_stable", 64'(stable), 64'd1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("hold_release", {61'd0, req_ready_o, rsp_valid_o, busy_o}, 64'b100);

    // Flush at CALC cycle 12, then a flush coinciding with a request.
    send(MD_MULL, 1'b0, 1'b0, 32'h1234, 32'h5678);
    repeat (11) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_idle", {62'd0, req_ready_o, busy_o}, 64'b10);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid_o) pulses++;
      @(negedge clk_i);
    end
    check("flush_no_rsp", 64'(pulses), 64'd0);
    op_i = MD_DIV; op_a_i = 32'd9; op_b_i = 32'd3; req_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_blocks_req", 64'(busy_o), 64'd0);
    do_op("div_9_3", MD_DIV, 1'b0, 1'b0, 32'd9, 32'd3, 0);

    // Asynchronous reset mid-CALC.
    send(MD_DIV, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 check("async_reset", {29'd0, req_ready_o, rsp_valid_o, busy_o, result_o}, {29'd0, 3'b100, 32'd0});
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      do_op($sformatf("rnd%0d", i), md_op_e'(2'($urandom_range(0, 3))),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
